// File: rtl/alu_bist.sv
// Built-in self-test engine for the processor ALU: sweeps every supported opcode with
// fixed corner vectors plus LFSR operands and compares res/flags against a golden model.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; done/pass/fail_* hold the last run's result
// APPLY | drive operands and opcode for the current vector
// WAIT  | let the ALU settle for SETTLE cycles
// CHECK | compare ALU outputs with the golden model, step vector/op
// DONE  | publish done/pass, drop busy
module alu_bist #(
   parameter int          N       = 4,
   parameter int          VECTORS = 8,
   parameter int          SETTLE  = 1,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_ctrl,
   input  logic [N-1:0] alu_res,
   input  logic [3:0]   alu_flags,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [7:0]   fail_count,
   output logic [2:0]   fail_op,
   output logic [N-1:0] fail_a,
   output logic [N-1:0] fail_b
);

   localparam int VW = $clog2(VECTORS + 1);
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [VW-1:0] VEC_LAST = VW'(VECTORS - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MOD = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [2:0]     op_cnt;
   logic [VW-1:0]  vec_cnt;
   logic [SW-1:0]  wait_cnt;
   logic [15:0]    lfsr;
   logic [15:0]    lfsr_nxt;
   logic [2:0]     cur_op;
   logic [N-1:0]   vec_a;
   logic [N-1:0]   vec_b;
   logic [N:0]     sum;
   logic [N-1:0]   gold_res;
   logic [3:0]     gold_flags;
   logic           gold_c;
   logic           gold_v;
   logic           mismatch;

   always_comb lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // op_cnt counts down from 5, so it maps to the sweep order ADD first, SRL last
   always_comb begin
      case (op_cnt)
         3'd5:    cur_op = OP_ADD;
         3'd4:    cur_op = OP_SUB;
         3'd3:    cur_op = OP_MOD;
         3'd2:    cur_op = OP_AND;
         3'd1:    cur_op = OP_MUL;
         default: cur_op = OP_SRL;
      endcase
   end

   always_comb begin
      vec_a = '0;
      vec_b = '0;
      if (vec_cnt == VEC_LAST) begin
         vec_a = '0;
         vec_b = '0;
      end else if (vec_cnt == VEC_LAST - VW'(1)) begin
         vec_a = '1;
         vec_b = '1;
      end else begin
         vec_a = lfsr[N-1:0];
         vec_b = lfsr[2*N-1:N];
      end
      if (cur_op == OP_MOD && vec_b == '0)
         vec_b = N'(1);
   end

   always_comb begin
      sum      = '0;
      gold_res = '0;
      gold_c   = 1'b0;
      gold_v   = 1'b0;
      case (alu_ctrl)
         OP_ADD: begin
            sum      = {1'b0, alu_a} + {1'b0, alu_b};
            gold_res = sum[N-1:0];
            gold_c   = sum[N];
            gold_v   = (alu_a[N-1] == alu_b[N-1]) && (gold_res[N-1] != alu_a[N-1]);
         end
         OP_SUB: begin
            sum      = {1'b0, alu_a} - {1'b0, alu_b};
            gold_res = sum[N-1:0];
            gold_c   = ~sum[N];
            gold_v   = (alu_a[N-1] != alu_b[N-1]) && (gold_res[N-1] != alu_a[N-1]);
         end
         OP_MOD:  gold_res = (alu_b == '0) ? '0 : alu_a % alu_b;
         OP_AND:  gold_res = alu_a & alu_b;
         OP_MUL:  gold_res = alu_a * alu_b;
         OP_SRL:  gold_res = alu_a >> 1;
         default: gold_res = '0;
      endcase
      gold_flags = {gold_res[N-1], gold_res == '0, gold_c, gold_v};
      mismatch   = (alu_res != gold_res) || (alu_flags != gold_flags);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_APPLY;
         S_APPLY: state_nxt = S_WAIT;
         S_WAIT:  if (wait_cnt == '0) state_nxt = S_CHECK;
         S_CHECK: state_nxt = (vec_cnt == '0 && op_cnt == 3'd0) ? S_DONE : S_APPLY;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= 3'b000;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_count <= 8'd0;
         fail_op    <= 3'b000;
         fail_a     <= '0;
         fail_b     <= '0;
         lfsr       <= SEED;
         op_cnt     <= 3'd5;
         vec_cnt    <= VEC_LAST;
         wait_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  fail_count <= 8'd0;
                  fail_op    <= 3'b000;
                  fail_a     <= '0;
                  fail_b     <= '0;
                  lfsr       <= SEED;
                  op_cnt     <= 3'd5;
                  vec_cnt    <= VEC_LAST;
               end
            end
            S_APPLY: begin
               alu_a    <= vec_a;
               alu_b    <= vec_b;
               alu_ctrl <= cur_op;
               wait_cnt <= SW'(SETTLE - 1);
               // the LFSR value is consumed first, then stepped for the next random vector
               if (vec_cnt < VEC_LAST - VW'(1))
                  lfsr <= lfsr_nxt;
            end
            S_WAIT: begin
               if (wait_cnt != '0)
                  wait_cnt <= wait_cnt - SW'(1);
            end
            S_CHECK: begin
               if (mismatch) begin
                  if (fail_count == 8'd0) begin
                     fail_op <= alu_ctrl;
                     fail_a  <= alu_a;
                     fail_b  <= alu_b;
                  end
                  if (fail_count != 8'hFF)
                     fail_count <= fail_count + 8'd1;
               end
               if (vec_cnt == '0) begin
                  vec_cnt <= VEC_LAST;
                  if (op_cnt != 3'd0)
                     op_cnt <= op_cnt - 3'd1;
               end else begin
                  vec_cnt <= vec_cnt - VW'(1);
               end
            end
            S_DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
               pass <= (fail_count == 8'd0);
            end
            default: ;
         endcase
      end
   end

endmodule
